// File: rtl/tristate_bus_tx_ctrl_pkg.sv
// rtl/tristate_bus_tx_ctrl_pkg.sv - shared FSM state encoding and sizing helper for the bus transmit controller
package tristate_bus_tx_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRIVE = 2'd2,
        ST_TURN  = 2'd3
    } state_t;

    // Bits needed to hold any value 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/tristate_bus_tx_ctrl_fifo.sv
// rtl/tristate_bus_tx_ctrl_fifo.sv - synchronous word FIFO feeding the bus transmit FSM
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   push, push_data    write request and word; ignored while full
//   pop                read request; ignored while empty
//   head               word at the read pointer (valid when !empty)
//   full, empty        occupancy flags
//   level              current occupancy 0..DEPTH
module tristate_bus_tx_ctrl_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses a push even if a pop frees a slot this same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);
    assign head  = mem[rd_ptr];

    // Storage is not reset: contents are dead once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (!do_push && do_pop) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/tristate_bus_tx_ctrl.sv
// rtl/tristate_bus_tx_ctrl.sv - buffers producer words and drives them onto a shared tristate bus in granted bursts
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_data, in_valid    producer word and valid
//   in_ready             high when the FIFO can accept a word (!full)
//   bus_req              request to the bus arbiter
//   bus_gnt              grant from the bus arbiter
//   bus_data, bus_en     to the tristate driver data_in/en; data is 0 when not driving
//   level                FIFO occupancy
module tristate_bus_tx_ctrl
    import tristate_bus_tx_ctrl_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int DEPTH      = 4,
    parameter int MAX_BURST  = 4,
    parameter int TURNAROUND = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       bus_req,
    input  logic                       bus_gnt,
    output logic [WIDTH-1:0]           bus_data,
    output logic                       bus_en,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int LVL_W  = $clog2(DEPTH) + 1;
    localparam int BEAT_W = cnt_width(MAX_BURST);
    localparam int TURN_W = cnt_width(TURNAROUND);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);
    localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURNAROUND - 1);

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [TURN_W-1:0]   turn_q, turn_d;
    logic                pop;
    logic [WIDTH-1:0]    head;
    logic                fifo_full;
    logic                fifo_empty;

    tristate_bus_tx_ctrl_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    assign in_ready = !fifo_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            turn_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            turn_q  <= turn_d;
        end
    end

    // Bus outputs are decoded straight from state and bus_gnt so that a
    // grant withdrawn mid-burst takes bus_en down in the same cycle.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        turn_d   = turn_q;
        pop      = 1'b0;
        bus_req  = 1'b0;
        bus_en   = 1'b0;
        bus_data = '0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                bus_req = 1'b1;
                if (bus_gnt) begin
                    state_d = ST_DRIVE;
                    beat_d  = '0;
                end
            end

            ST_DRIVE: begin
                bus_req = 1'b1;
                if (bus_gnt) begin
                    bus_en   = 1'b1;
                    bus_data = head;
                    pop      = 1'b1;
                    beat_d   = beat_q + 1'b1;
                    // End on the pre-pop level so a word pushed this cycle
                    // waits for the next burst instead of extending this one.
                    if ((beat_q == LAST_BEAT) || (level == LVL_W'(1))) begin
                        state_d = ST_TURN;
                        turn_d  = TURN_LOAD;
                    end
                end else begin
                    // Grant lost: head stays in the FIFO for the next grant.
                    state_d = ST_TURN;
                    turn_d  = TURN_LOAD;
                end
            end

            ST_TURN: begin
                if (turn_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    turn_d = turn_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tristate_bus_tx_ctrl.sv
// tb/tb_tristate_bus_tx_ctrl.sv - self-checking bench for tristate_bus_tx_ctrl
module tb_tristate_bus_tx_ctrl;

    localparam int WIDTH      = 4;
    localparam int DEPTH      = 4;
    localparam int MAX_BURST  = 4;
    localparam int TURNAROUND = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             bus_req;
    logic             bus_gnt = 1'b0;
    logic [WIDTH-1:0] bus_data;
    logic             bus_en;
    logic [2:0]       level;

    always #5 clk = ~clk;

    tristate_bus_tx_ctrl #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .MAX_BURST  (MAX_BURST),
        .TURNAROUND (TURNAROUND)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .bus_req  (bus_req),
        .bus_gnt  (bus_gnt),
        .bus_data (bus_data),
        .bus_en   (bus_en),
        .level    (level)
    );

    typedef struct {
        logic             rst;
        logic             v;
        logic [WIDTH-1:0] d;
        logic             g;
        logic             req;
        logic             en;
        logic [WIDTH-1:0] data;
        logic [2:0]       lvl;
        logic             rdy;
    } vec_t;

    vec_t             tbl[$];
    logic [WIDTH-1:0] sb_q[$];
    int               n_checks = 0;
    int               n_errors = 0;
    int               low_run  = 0;
    int               high_run = 0;
    bit               seen_high = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s [%0d] got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic v, input logic [WIDTH-1:0] d, input logic g,
                                input logic req, input logic en, input logic [WIDTH-1:0] data,
                                input logic [2:0] lvl, input logic rdy);
        vec_t x;
        x.rst = r; x.v = v; x.d = d; x.g = g;
        x.req = req; x.en = en; x.data = data; x.lvl = lvl; x.rdy = rdy;
        return x;
    endfunction

    // Scoreboard and bus-protocol checks, sampled at the falling edge.
    task automatic monitor();
        if (rst) begin
            sb_q.delete();
            seen_high = 0;
            low_run   = 0;
            high_run  = 0;
        end else begin
            chk("en_without_gnt", 0, {31'd0, bus_en && !bus_gnt}, 32'd0);
            if (bus_en) begin
                if (seen_high && low_run > 0) begin
                    chk("turn_gap", low_run, {31'd0, low_run >= TURNAROUND}, 32'd1);
                end
                high_run++;
                chk("burst_len", high_run, {31'd0, high_run <= MAX_BURST}, 32'd1);
                low_run   = 0;
                seen_high = 1;
                chk("sb_nonempty", 0, {31'd0, sb_q.size() > 0}, 32'd1);
                if (sb_q.size() > 0) begin
                    chk("sb_data", 0, 32'(bus_data), 32'(sb_q.pop_front()));
                end
            end else begin
                low_run++;
                high_run = 0;
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(in_data);
            end
        end
    endtask

    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic g, input logic r);
        @(posedge clk);
        #1;
        in_valid = v;
        in_data  = d;
        bus_gnt  = g;
        rst      = r;
        @(negedge clk);
        monitor();
    endtask

    initial begin
        // Test 1: single word 5 with grant held high.
        tbl.push_back(mk(1, 0, 0, 1,  0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 5, 1,  0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1,  0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1,  1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1,  1, 1, 5, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1,  0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1,  0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1,  0, 0, 0, 0, 1));
        // Test 2/4: fill to full, refused push, full-burst drain, word 2 follows.
        tbl.push_back(mk(0, 1, 5, 0,  0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 7, 0,  0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 3, 0,  1, 0, 0, 2, 1));
        tbl.push_back(mk(0, 1, 1, 0,  1, 0, 0, 3, 1));
        tbl.push_back(mk(0, 1, 2, 0,  1, 0, 0, 4, 0));
        tbl.push_back(mk(0, 1, 2, 1,  1, 0, 0, 4, 0));
        tbl.push_back(mk(0, 1, 2, 1,  1, 1, 5, 4, 0));
        tbl.push_back(mk(0, 1, 2, 1,  1, 1, 7, 3, 1));
        tbl.push_back(mk(0, 0, 0, 1,  1, 1, 3, 3, 1));
        tbl.push_back(mk(0, 0, 0, 1,  1, 1, 1, 2, 1));
        tbl.push_back(mk(0, 0, 0, 1,  0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1,  0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1,  1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1,  1, 1, 2, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 1));

        step(0, 0, 1, 1);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].g, tbl[i].rst);
            chk("tbl_req",   i, 32'(bus_req),  32'(tbl[i].req));
            chk("tbl_en",    i, 32'(bus_en),   32'(tbl[i].en));
            chk("tbl_data",  i, 32'(bus_data), 32'(tbl[i].data));
            chk("tbl_level", i, 32'(level),    32'(tbl[i].lvl));
            chk("tbl_ready", i, 32'(in_ready), 32'(tbl[i].rdy));
        end

        // Test 3: grant withdrawn after the first of two beats.
        step(1, 9, 0, 0);
        step(1, 6, 0, 0);
        step(0, 0, 1, 0);
        chk("abort_req", 0, 32'(bus_req), 32'd1);
        chk("abort_lvl", 0, 32'(level), 32'd2);
        step(0, 0, 1, 0);
        chk("abort_beat_en", 0, 32'(bus_en), 32'd1);
        chk("abort_beat_data", 0, 32'(bus_data), 32'd9);
        step(0, 0, 0, 0);
        chk("abort_en", 0, 32'(bus_en), 32'd0);
        chk("abort_data", 0, 32'(bus_data), 32'd0);
        chk("abort_lvl", 1, 32'(level), 32'd1);
        step(0, 0, 1, 0);
        chk("abort_turn_en", 0, 32'(bus_en), 32'd0);
        chk("abort_turn_req", 0, 32'(bus_req), 32'd0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("retry_req", 0, 32'(bus_req), 32'd1);
        step(0, 0, 1, 0);
        chk("retry_en", 0, 32'(bus_en), 32'd1);
        chk("retry_data", 0, 32'(bus_data), 32'd6);
        step(0, 0, 1, 0);
        chk("retry_lvl", 0, 32'(level), 32'd0);

        // Test 5: reset sampled mid-burst with three words left.
        step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 2, 0, 0);
        step(1, 3, 0, 0);
        step(1, 4, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("rst_pre_data", 0, 32'(bus_data), 32'd1);
        step(0, 0, 1, 1);
        chk("rst_pre_lvl", 0, 32'(level), 32'd3);
        chk("rst_pre_en", 0, 32'(bus_en), 32'd1);
        step(0, 0, 1, 0);
        chk("rst_en", 0, 32'(bus_en), 32'd0);
        chk("rst_req", 0, 32'(bus_req), 32'd0);
        chk("rst_lvl", 0, 32'(level), 32'd0);
        chk("rst_ready", 0, 32'(in_ready), 32'd1);
        step(0, 0, 1, 0);
        chk("rst_idle_en", 0, 32'(bus_en), 32'd0);

        // Test 6: random traffic, then drain with grant held.
        for (int c = 0; c < 2000; c++) begin
            step(1'($urandom_range(0, 1)), WIDTH'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0), 1'b0);
        end
        begin
            int waited = 0;
            while (level != 0 && waited < 200) begin
                step(0, 0, 1, 0);
                waited++;
            end
            chk("drain_timeout", waited, {31'd0, waited < 200}, 32'd1);
        end
        for (int c = 0; c < 4; c++) begin
            step(0, 0, 1, 0);
        end
        chk("sb_empty", 0, 32'(sb_q.size()), 32'd0);
        chk("final_en", 0, 32'(bus_en), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
